// File: rtl/move_event_gen_pkg.sv
// rtl/move_event_gen_pkg.sv - shared direction type and button count for the move event generator
package game_pkg;

   localparam int NUM_BTNS = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   // Fixed priority up > down > left > right: lower-priority tests first, winner overwrites
   function automatic dir_t pick_dir(input logic [NUM_BTNS-1:0] edges);
      dir_t d;
      d = DIR_UP;
      if (edges[3]) d = DIR_RIGHT;
      if (edges[2]) d = DIR_LEFT;
      if (edges[1]) d = DIR_DOWN;
      if (edges[0]) d = DIR_UP;
      return d;
   endfunction

endpackage

// File: rtl/move_event_gen_if.sv
// rtl/move_event_gen_if.sv - valid/ready move event channel toward the board-update FSM
interface move_event_gen_if;
   import game_pkg::*;

   logic move_valid;
   logic move_ready;
   dir_t move_dir;

   modport master (
      output move_valid,
      output move_dir,
      input  move_ready
   );

   modport slave (
      input  move_valid,
      input  move_dir,
      output move_ready
   );

endinterface

// File: rtl/move_event_gen_debounce.sv
// rtl/move_event_gen_debounce.sv - per-button debounce counter, stable level and press edge
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic p,
   output logic stable,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_q, stable_d;
   logic             prev_q, prev_d;

   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      prev_d   = stable_q;
      if (p == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = p;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q    <= '0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
         prev_q   <= prev_d;
      end
   end

   assign stable = stable_q;
   // Edge is seen in the cycle after the flip registers; releases are ignored
   assign press  = stable_q & ~prev_q;

endmodule

// File: rtl/move_event_gen.sv
// rtl/move_event_gen.sv - turns four debounced direction buttons into single move events
module move_event_gen
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic [NUM_BTNS-1:0] btn_sync,
   move_event_gen_if.master    mv,
   output logic [NUM_BTNS-1:0] btn_state,
   output logic                overflow
);

   logic [NUM_BTNS-1:0] p;
   logic [NUM_BTNS-1:0] stable;
   logic [NUM_BTNS-1:0] press;

   logic valid_q, valid_d;
   dir_t dir_q, dir_d;
   logic free;
   logic cand;
   logic multi;

   assign p = btn_sync ^ {NUM_BTNS{ACTIVE_LOW}};

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_debounce (
         .Clk    (Clk),
         .Reset_n(Reset_n),
         .p      (p[i]),
         .stable (stable[i]),
         .press  (press[i])
      );
   end

   always_comb begin
      valid_d  = valid_q;
      dir_d    = dir_q;
      free     = !valid_q || mv.move_ready;
      cand     = |press;
      multi    = |(press & (press - NUM_BTNS'(1)));
      if (cand && free) begin
         valid_d = 1'b1;
         dir_d   = pick_dir(press);
      end else if (!cand && mv.move_ready) begin
         valid_d = 1'b0;
      end
      // Any edge that did not make it into the slot: priority losers or a full slot
      overflow = multi || (cand && !free);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid_q <= 1'b0;
         dir_q   <= DIR_UP;
      end else begin
         valid_q <= valid_d;
         dir_q   <= dir_d;
      end
   end

   assign mv.move_valid = valid_q;
   assign mv.move_dir   = dir_q;
   assign btn_state     = stable;

endmodule

// File: tb/tb_move_event_gen.sv
// tb/tb_move_event_gen.sv - directed bench for move_event_gen with a per-cycle reference model
`timescale 1ns/1ps
module tb_move_event_gen;
   import game_pkg::*;

   localparam int D    = 4;
   localparam int MASK = (1 << D) - 1;

   logic       Clk      = 1'b0;
   logic       Reset_n  = 1'b0;
   logic [3:0] btn_sync = 4'hF;
   logic [3:0] btn_state;
   logic       overflow;

   int n_checks = 0;
   int n_fail   = 0;

   move_event_gen_if mv_if();

   move_event_gen #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .btn_sync (btn_sync),
      .mv       (mv_if.master),
      .btn_state(btn_state),
      .overflow (overflow)
   );

   always #5 Clk = ~Clk;

   // Model: a button's level flips once its last D samples all disagree with it
   logic [3:0] m_stable = 4'h0;
   logic [3:0] m_prev   = 4'h0;
   logic       m_valid  = 1'b0;
   logic [1:0] m_dir    = 2'd0;
   int         m_hist[4];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge Clk or negedge Reset_n) begin
      logic [3:0] pr;
      logic       fr;
      if (!Reset_n) begin
         m_stable = 4'h0;
         m_prev   = 4'h0;
         m_valid  = 1'b0;
         m_dir    = 2'd0;
         for (int i = 0; i < 4; i++) m_hist[i] = 0;
      end else begin
         pr = m_stable & ~m_prev;
         fr = !m_valid || mv_if.move_ready;
         if (pr != 4'h0 && fr) begin
            m_valid = 1'b1;
            for (int i = 3; i >= 0; i--) if (pr[i]) m_dir = 2'(i);
         end else if (pr == 4'h0 && mv_if.move_ready) begin
            m_valid = 1'b0;
         end
         m_prev = m_stable;
         for (int i = 0; i < 4; i++) begin
            m_hist[i] = ((m_hist[i] << 1) | (btn_sync[i] ? 0 : 1)) & MASK;
            if (!m_stable[i] && m_hist[i] == MASK) m_stable[i] = 1'b1;
            else if (m_stable[i] && m_hist[i] == 0) m_stable[i] = 1'b0;
         end
      end
   end

   always @(negedge Clk) begin
      logic [3:0] cp;
      int         npress;
      int         loaded;
      cp     = m_stable & ~m_prev;
      npress = $countones(cp);
      loaded = (npress > 0 && (!m_valid || mv_if.move_ready)) ? 1 : 0;
      chk("model_btn_state", int'(btn_state), int'(m_stable));
      chk("model_valid", int'(mv_if.move_valid), int'(m_valid));
      chk("model_dir", int'(mv_if.move_dir), int'(m_dir));
      chk("model_overflow", int'(overflow), (npress > loaded) ? 1 : 0);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      mv_if.move_ready = 1'b0;
      step(2);
      chk("reset_valid", int'(mv_if.move_valid), 0);
      chk("reset_btn_state", int'(btn_state), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_dir", int'(mv_if.move_dir), 0);
      Reset_n = 1'b1;
      step(2);

      // Clean press of UP
      btn_sync[0] = 1'b0;
      step(3);
      chk("clean_state_c3", int'(btn_state[0]), 0);
      step(1);
      chk("clean_state_c4", int'(btn_state[0]), 1);
      chk("clean_valid_c4", int'(mv_if.move_valid), 0);
      step(1);
      chk("clean_valid_c5", int'(mv_if.move_valid), 1);
      chk("clean_dir_c5", int'(mv_if.move_dir), int'(DIR_UP));
      step(3);
      chk("clean_hold_valid", int'(mv_if.move_valid), 1);
      mv_if.move_ready = 1'b1;
      step(1);
      chk("clean_drain", int'(mv_if.move_valid), 0);
      mv_if.move_ready = 1'b0;
      step(8);
      chk("clean_no_repeat", int'(mv_if.move_valid), 0);
      btn_sync = 4'hF;
      step(6);
      chk("clean_release", int'(btn_state), 0);

      // Glitch rejection, twice to show the counter restarts
      btn_sync[2] = 1'b0;
      step(3);
      btn_sync[2] = 1'b1;
      step(6);
      btn_sync[2] = 1'b0;
      step(3);
      btn_sync[2] = 1'b1;
      step(4);
      chk("glitch_state", int'(btn_state), 0);
      chk("glitch_valid", int'(mv_if.move_valid), 0);

      // Simultaneous DOWN and RIGHT
      btn_sync = 4'b0101;
      step(4);
      chk("simul_overflow", int'(overflow), 1);
      chk("simul_state", int'(btn_state), 4'b1010);
      step(1);
      chk("simul_valid", int'(mv_if.move_valid), 1);
      chk("simul_dir", int'(mv_if.move_dir), int'(DIR_DOWN));
      chk("simul_overflow_gone", int'(overflow), 0);
      mv_if.move_ready = 1'b1;
      step(1);
      mv_if.move_ready = 1'b0;
      btn_sync = 4'hF;
      step(6);

      // Full slot: LEFT edge while UP is pending
      btn_sync[0] = 1'b0;
      step(5);
      chk("full_up_pending", int'(mv_if.move_valid), 1);
      btn_sync[2] = 1'b0;
      step(4);
      chk("full_overflow", int'(overflow), 1);
      chk("full_dir_edge", int'(mv_if.move_dir), int'(DIR_UP));
      step(1);
      chk("full_overflow_gone", int'(overflow), 0);
      chk("full_dir_after", int'(mv_if.move_dir), int'(DIR_UP));
      mv_if.move_ready = 1'b1;
      step(1);
      chk("full_drain", int'(mv_if.move_valid), 0);
      mv_if.move_ready = 1'b0;
      btn_sync = 4'hF;
      step(6);

      // Back-to-back: RIGHT edge coincides with the accepting cycle
      btn_sync[0] = 1'b0;
      step(5);
      btn_sync[3] = 1'b0;
      step(4);
      mv_if.move_ready = 1'b1;
      #1;
      chk("b2b_no_overflow", int'(overflow), 0);
      step(1);
      chk("b2b_valid", int'(mv_if.move_valid), 1);
      chk("b2b_dir", int'(mv_if.move_dir), int'(DIR_RIGHT));
      step(1);
      chk("b2b_drain", int'(mv_if.move_valid), 0);
      mv_if.move_ready = 1'b0;
      btn_sync = 4'hF;
      step(6);

      // Async reset with DOWN pending and UP mid-debounce
      btn_sync[1] = 1'b0;
      step(5);
      chk("areset_pending", int'(mv_if.move_dir), int'(DIR_DOWN));
      btn_sync[0] = 1'b0;
      step(2);
      Reset_n     = 1'b0;
      btn_sync[1] = 1'b1;
      #1;
      chk("areset_valid", int'(mv_if.move_valid), 0);
      chk("areset_dir", int'(mv_if.move_dir), 0);
      chk("areset_state", int'(btn_state), 0);
      chk("areset_overflow", int'(overflow), 0);
      #1;
      Reset_n = 1'b1;
      step(3);
      chk("areset_redebounce_c3", int'(btn_state), 0);
      step(1);
      chk("areset_redebounce_c4", int'(btn_state), 4'b0001);
      chk("areset_valid_c4", int'(mv_if.move_valid), 0);
      step(1);
      chk("areset_valid_c5", int'(mv_if.move_valid), 1);
      chk("areset_dir_c5", int'(mv_if.move_dir), int'(DIR_UP));
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
